rr_stream_mux: RTL and testbench
================================

# rr_stream_mux

Round-robin stream multiplexer that merges `NumReq` valid/ready input streams into one registered output stream. It sits directly downstream of the request sources that feed the round-robin arbiter. It replaces the free-running grant with a handshake-aware grant: a winner is committed only when its beat is actually accepted. The rotating pointer advances only on accepted beats, which keeps fairness exact under downstream backpressure.

## Interface
- `Clog2NumReq`, default 2: log2 of the requester count.
- `NumReq`, default `2**Clog2NumReq`: number of input streams (derived; do not override).
- `DataWidth`, default 8: payload width per stream.

- `clk_i`  in  1  clock; all state updates on the rising edge.
- `arst_ni`  in  1  reset, synchronous and active-low: sampled on the `clk_i` rising edge.
- `req_valid_i`  in  NumReq  per-stream valid.
- `req_data_i`  in  NumReq*DataWidth  flattened payloads; stream k occupies bits `[k*DataWidth +: DataWidth]`.
- `req_ready_o`  out  NumReq  per-stream ready; at most one bit high.
- `out_valid_o`  out  1  output register holds a beat.
- `out_data_o`  out  DataWidth  registered payload.
- `out_idx_o`  out  Clog2NumReq  index of the source stream of the current beat.
- `out_ready_i`  in  1  downstream accepts the beat when `out_valid_o && out_ready_i`.

## Operation
- State:
  - one-entry output register holding valid, data and idx;
  - pointer `ptr` (Clog2NumReq bits) holding the last accepted index.
- Winner selection (combinational): the first k with `req_valid_i[k]=1`, searching `ptr+1, ptr+2, …` modulo NumReq. The search wraps from NumReq-1 to 0.
- `can_load = !out_valid_o || out_ready_i`.
- `req_ready_o[winner] = can_load`. All other ready bits are 0. With no valid input, all ready bits are 0.
- `req_ready_o` depends combinationally on `req_valid_i` and `out_ready_i`.
- Upstream obligations:
  - must not make valid depend on ready;
  - must hold valid and data stable until accepted.
- Accept, when `can_load` and any valid is set:
  - register ← {1, winner data, winner};
  - `ptr` ← winner.
- Drain only (`out_valid_o && out_ready_i`, no valid input): `out_valid_o` ← 0. Data and idx hold their last value.
- Simultaneous drain and load in the same cycle: the old beat leaves and the new beat is loaded. Throughput is 1 beat/cycle.
- Backpressure (`out_valid_o && !out_ready_i`):
  - all `req_ready_o` are 0;
  - register and `ptr` are unchanged;
  - output contents stay stable until accepted.
- A requester that drops valid before being granted loses its turn. No state records it.
- Reset values:
  - `out_valid_o=0`, `out_data_o=0`, `out_idx_o=0`;
  - `ptr=NumReq-1`, so index 0 has top priority after reset;
  - while `arst_ni=0`, all `req_ready_o` are forced to 0.
- Reset asserted mid-operation: any held beat is discarded with no handshake. The next state is the reset state above.

## Timing
- Latency: 1 cycle. A beat accepted at edge N is visible on `out_*` after edge N.
- Ready is combinational within the cycle; there is no bubble between consecutive beats.
- `ptr` updates on the same edge that loads the register. The next winner search uses the updated `ptr`.
- Fairness: with all inputs continuously valid, each stream is granted exactly once per NumReq accepted beats. Stalled cycles do not count.
- Single persistent requester k: granted every accepted cycle, and `ptr` stays at k.

## Test plan
Configuration for all scenarios: NumReq=4, DataWidth=8, stream k data = `0x10+k` unless stated.

- **Reset:** hold `arst_ni=0` for 2 edges with all valids high.
  - `out_valid_o=0`, `out_data_o=0x00`, `out_idx_o=0`, `req_ready_o=4'b0000`.
  - First accepted beat after release has idx 0.
- **All valid, `out_ready_i=1`:**
  - `out_idx_o` sequence 0,1,2,3,0,1 on consecutive cycles;
  - data 0x10,0x11,0x12,0x13,…;
  - `out_valid_o` high every cycle after the first.
- **`req_valid_i=4'b1010`, `out_ready_i=1`:**
  - idx alternates 1,3,1,3;
  - `req_ready_o` alternates 4'b0010 and 4'b1000.
- **Backpressure, all valid:** drive `out_ready_i=0` for 3 cycles while holding idx 1.
  - `out_data_o` stays 0x11;
  - `req_ready_o=0` for those 3 cycles.
  - After `out_ready_i=1`: idx 2,3,0 follow with no bubble.
- **Single requester:** only stream 2 valid, data 0xA5, `out_ready_i=1` for 5 cycles.
  - 5 beats, all with idx 2 and data 0xA5;
  - `req_ready_o=4'b0100` every cycle.
- **Mid-stream reset:** assert `arst_ni=0` for 1 edge while `out_valid_o=1` with idx 2.
  - After that edge, `out_valid_o=0`.
  - After release with all valid, first beat has idx 0.

Source files
------------

// File: rtl/rr_stream_mux.sv
// Round-robin merge of NumReq valid/ready streams into one registered output beat.
// The rotating pointer only moves on accepted beats, so backpressure never skews fairness.
module rr_stream_mux #(
    parameter int Clog2NumReq = 2,
    parameter int NumReq      = 2 ** Clog2NumReq,
    parameter int DataWidth   = 8
) (
    input  logic                        clk_i,
    input  logic                        arst_ni,
    input  logic [NumReq-1:0]           req_valid_i,
    input  logic [NumReq*DataWidth-1:0] req_data_i,
    output logic [NumReq-1:0]           req_ready_o,
    output logic                        out_valid_o,
    output logic [DataWidth-1:0]        out_data_o,
    output logic [Clog2NumReq-1:0]      out_idx_o,
    input  logic                        out_ready_i
);

    logic [Clog2NumReq-1:0] ptr;
    logic [Clog2NumReq-1:0] winner;
    logic [Clog2NumReq-1:0] cand;
    logic [DataWidth-1:0]   win_data;
    logic                   any_valid;
    logic                   can_load;

    assign can_load = !out_valid_o || out_ready_i;

    // Search ptr+1 .. ptr+NumReq; the index arithmetic wraps because NumReq is a power of two.
    always_comb begin
        winner    = '0;
        cand      = '0;
        any_valid = 1'b0;
        for (int off = 1; off <= NumReq; off++) begin
            cand = ptr + Clog2NumReq'(off);
            if (!any_valid && req_valid_i[cand]) begin
                winner    = cand;
                any_valid = 1'b1;
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int k = 0; k < NumReq; k++) begin
            if (Clog2NumReq'(k) == winner) begin
                win_data = req_data_i[k*DataWidth +: DataWidth];
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (arst_ni && any_valid && can_load) begin
            req_ready_o[winner] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!arst_ni) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_idx_o   <= '0;
            ptr         <= '1;
        end else if (can_load) begin
            if (any_valid) begin
                out_valid_o <= 1'b1;
                out_data_o  <= win_data;
                out_idx_o   <= winner;
                ptr         <= winner;
            end else begin
                out_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Bench for rr_stream_mux: table of per-cycle stimulus with expected ready/valid,
// plus a scoreboard of expected beats pushed on grant and popped on output handshake.
module tb_rr_stream_mux;

    logic        clk = 1'b0;
    logic        arst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_idx;
    logic        out_ready;
    logic [7:0]  sdata [4];

    always #5 clk = ~clk;

    assign req_data = {sdata[3], sdata[2], sdata[1], sdata[0]};

    rr_stream_mux #(.Clog2NumReq(2), .DataWidth(8)) dut (
        .clk_i       (clk),
        .arst_ni     (arst_n),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_idx_o   (out_idx),
        .out_ready_i (out_ready)
    );

    typedef struct {
        logic       rst;
        logic [3:0] v;
        logic       ordy;
        logic [7:0] d2;
        logic [3:0] rdy;
        logic       ov;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic [1:0] idx;
    } beat_t;

    vec_t  vecs [$];
    beat_t sb   [$];
    int    n_checks = 0;
    int    n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic void add(input logic [3:0] v, input logic ordy, input logic [7:0] d2,
                                input logic [3:0] rdy, input logic ov);
        vec_t t;
        t.rst = 1'b0; t.v = v; t.ordy = ordy; t.d2 = d2; t.rdy = rdy; t.ov = ov;
        vecs.push_back(t);
    endfunction

    function automatic void add_rst();
        vec_t t;
        t.rst = 1'b1; t.v = 4'hF; t.ordy = 1'b0; t.d2 = 8'h12; t.rdy = 4'b0000; t.ov = 1'b0;
        vecs.push_back(t);
    endfunction

    // Holds reset for n edges; any beat in flight is discarded without a handshake.
    task automatic do_reset(input int n, input string tag);
        arst_n    = 1'b0;
        out_ready = 1'b0;
        req_valid = 4'hF;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("%s ready in reset", tag), 32'(req_ready), 32'h0);
            @(posedge clk);
            #1;
            check($sformatf("%s out_valid", tag), 32'(out_valid), 32'h0);
            check($sformatf("%s out_data", tag), 32'(out_data), 32'h0);
            check($sformatf("%s out_idx", tag), 32'(out_idx), 32'h0);
        end
        sb.delete();
        arst_n = 1'b1;
    endtask

    task automatic apply(input vec_t t, input int n);
        beat_t b;
        req_valid = t.v;
        out_ready = t.ordy;
        sdata[2]  = t.d2;
        @(negedge clk);
        check($sformatf("ready step %0d", n), 32'(req_ready), 32'(t.rdy));
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL beat step %0d: got idx %0d data 0x%0h, expected no beat", n, out_idx, out_data);
            end else begin
                b = sb.pop_front();
                check($sformatf("beat idx step %0d", n), 32'(out_idx), 32'(b.idx));
                check($sformatf("beat data step %0d", n), 32'(out_data), 32'(b.d));
            end
        end else if (out_valid && sb.size() > 0) begin
            check($sformatf("hold idx step %0d", n), 32'(out_idx), 32'(sb[0].idx));
            check($sformatf("hold data step %0d", n), 32'(out_data), 32'(sb[0].d));
        end
        for (int k = 0; k < 4; k++) begin
            if (t.rdy[k]) begin
                b.idx = 2'(k);
                b.d   = sdata[k];
                sb.push_back(b);
            end
        end
        @(posedge clk);
        #1;
        check($sformatf("out_valid step %0d", n), 32'(out_valid), 32'(t.ov));
    endtask

    initial begin
        arst_n    = 1'b0;
        req_valid = 4'hF;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) sdata[k] = 8'h10 + 8'(k);

        // All valid, free-flowing: two full rotations starting at index 0.
        for (int i = 0; i < 8; i++) add(4'hF, 1'b1, 8'h12, 4'(1 << (i % 4)), 1'b1);
        // Streams 1 and 3 only: grants alternate.
        add(4'b1010, 1'b1, 8'h12, 4'b0010, 1'b1);
        add(4'b1010, 1'b1, 8'h12, 4'b1000, 1'b1);
        add(4'b1010, 1'b1, 8'h12, 4'b0010, 1'b1);
        add(4'b1010, 1'b1, 8'h12, 4'b1000, 1'b1);
        // Backpressure while idx 1 is held, then resume with no bubble.
        add(4'hF, 1'b1, 8'h12, 4'b0001, 1'b1);
        add(4'hF, 1'b1, 8'h12, 4'b0010, 1'b1);
        for (int i = 0; i < 3; i++) add(4'hF, 1'b0, 8'h12, 4'b0000, 1'b1);
        add(4'hF, 1'b1, 8'h12, 4'b0100, 1'b1);
        add(4'hF, 1'b1, 8'h12, 4'b1000, 1'b1);
        add(4'hF, 1'b1, 8'h12, 4'b0001, 1'b1);
        // Single persistent requester on stream 2, then drain.
        for (int i = 0; i < 5; i++) add(4'b0100, 1'b1, 8'hA5, 4'b0100, 1'b1);
        add(4'b0000, 1'b1, 8'hA5, 4'b0000, 1'b0);
        // Reach idx 2 in the register, reset mid-stream, restart from index 0.
        add(4'hF, 1'b1, 8'h12, 4'b1000, 1'b1);
        add(4'hF, 1'b1, 8'h12, 4'b0001, 1'b1);
        add(4'hF, 1'b1, 8'h12, 4'b0010, 1'b1);
        add(4'hF, 1'b1, 8'h12, 4'b0100, 1'b1);
        add_rst();
        add(4'hF, 1'b1, 8'h12, 4'b0001, 1'b1);
        add(4'hF, 1'b1, 8'h12, 4'b0010, 1'b1);
        add(4'b0000, 1'b1, 8'h12, 4'b0000, 1'b0);

        do_reset(2, "reset");
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) begin
                check("midreset out_valid before", 32'(out_valid), 32'h1);
                check("midreset out_idx before", 32'(out_idx), 32'h2);
                do_reset(1, "midreset");
            end else begin
                apply(vecs[i], i);
            end
        end
        check("scoreboard empty", 32'(sb.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
